// File: rtl/frame_buf_sched.sv
// Triple-buffer bank scheduler for the SDRAM frame store.
// Hands the write and read ports tear-free bank addresses and load strobes.
module frame_buf_sched #(
    parameter int unsigned FRAME_WORDS = 384000,
    parameter int unsigned BANK_STRIDE = 524288,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              wr_frame_end_i,
    input  logic              rd_frame_start_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W-1:0] wr_max_addr_o,
    output logic              wr_load_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] rd_max_addr_o,
    output logic              rd_load_o,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  frames_written_o,
    output logic [CNT_W-1:0]  frames_dropped_o,
    output logic [CNT_W-1:0]  frames_repeated_o
);

    typedef enum logic [1:0] {IDLE, START, RUN} state_e;

    localparam logic [ADDR_W-1:0] FW = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] B1 = ADDR_W'(BANK_STRIDE);
    localparam logic [ADDR_W-1:0] B2 = ADDR_W'(2 * BANK_STRIDE);

    state_e             state_q, state_d;
    logic [1:0]         w_q, w_d, r_q, r_d, l_q, l_d;
    logic               fresh_q, fresh_d;
    logic               valid_q, valid_d;
    logic               wl_q, wl_d, rl_q, rl_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   dr_cnt_q, dr_cnt_d;
    logic [CNT_W-1:0]   rp_cnt_q, rp_cnt_d;
    logic [ADDR_W-1:0]  wa_q, wm_q, ra_q, rm_q;

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] b);
        case (b)
            2'd1:    base_of = B1;
            2'd2:    base_of = B2;
            default: base_of = '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == '1) ? c : c + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        r_d      = r_q;
        l_d      = l_q;
        fresh_d  = fresh_q;
        valid_d  = valid_q;
        wl_d     = 1'b0;
        rl_d     = 1'b0;
        wr_cnt_d = wr_cnt_q;
        dr_cnt_d = dr_cnt_q;
        rp_cnt_d = rp_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = START;
                    wl_d    = 1'b1;
                    rl_d    = 1'b1;
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    w_d     = 2'd0;
                    r_d     = 2'd2;
                    l_d     = 2'd1;
                    fresh_d = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    if (wr_frame_end_i) begin
                        l_d      = w_q;
                        w_d      = 2'd3 - w_q - r_q;
                        fresh_d  = 1'b1;
                        valid_d  = 1'b1;
                        wl_d     = 1'b1;
                        wr_cnt_d = sat_inc(wr_cnt_q);
                        if (fresh_q) dr_cnt_d = sat_inc(dr_cnt_q);
                    end
                    // A simultaneous reader takes the frame that just closed
                    if (rd_frame_start_i) begin
                        rl_d = 1'b1;
                        if (wr_frame_end_i) begin
                            r_d     = w_q;
                            fresh_d = 1'b0;
                        end else if (fresh_q) begin
                            r_d     = l_q;
                            fresh_d = 1'b0;
                        end else begin
                            rp_cnt_d = sat_inc(rp_cnt_q);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            w_q      <= 2'd0;
            r_q      <= 2'd2;
            l_q      <= 2'd1;
            fresh_q  <= 1'b0;
            valid_q  <= 1'b0;
            wl_q     <= 1'b0;
            rl_q     <= 1'b0;
            wr_cnt_q <= '0;
            dr_cnt_q <= '0;
            rp_cnt_q <= '0;
            wa_q     <= '0;
            wm_q     <= FW;
            ra_q     <= B2;
            rm_q     <= B2 + FW;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            r_q      <= r_d;
            l_q      <= l_d;
            fresh_q  <= fresh_d;
            valid_q  <= valid_d;
            wl_q     <= wl_d;
            rl_q     <= rl_d;
            wr_cnt_q <= wr_cnt_d;
            dr_cnt_q <= dr_cnt_d;
            rp_cnt_q <= rp_cnt_d;
            wa_q     <= base_of(w_d);
            wm_q     <= base_of(w_d) + FW;
            ra_q     <= base_of(r_d);
            rm_q     <= base_of(r_d) + FW;
        end
    end

    assign wr_addr_o         = wa_q;
    assign wr_max_addr_o     = wm_q;
    assign wr_load_o         = wl_q;
    assign rd_addr_o         = ra_q;
    assign rd_max_addr_o     = rm_q;
    assign rd_load_o         = rl_q;
    assign rd_valid_o        = valid_q;
    assign frames_written_o  = wr_cnt_q;
    assign frames_dropped_o  = dr_cnt_q;
    assign frames_repeated_o = rp_cnt_q;

endmodule
